// File: rtl/merge_pass_engine.sv
// Bottom-up merge-sort engine: merges adjacent run pairs between two ping-pong
// banks, doubling the run width each pass until a single run spans the stream.
module merge_pass_engine #(
   parameter int ELEM_W    = 64,
   parameter int ADDR_W    = 12,
   parameter int START_RUN = 16,
   parameter int LEN_W     = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start_in,
   input  logic                descend_in,
   input  logic [LEN_W-1:0]    stream_len_in,
   output logic                rd_en_out,
   output logic [ADDR_W-1:0]   rd_addr_out,
   input  logic [2*ELEM_W-1:0] rd_data_in,
   output logic                wr_en_out,
   output logic [ADDR_W-1:0]   wr_addr_out,
   output logic [2*ELEM_W-1:0] wr_data_out,
   input  logic                mem_ready_in,
   output logic                src_bank_out,
   output logic                busy_out,
   output logic                done_out,
   output logic                err_out,
   output logic [7:0]          pass_cnt_out
);
   localparam int LW = LEN_W + 1;
   localparam logic [LW-1:0] RUN0 = LW'(START_RUN);
   localparam logic [LW-1:0] WMAX = LW'(1) << (ADDR_W + 1);

   typedef enum logic [2:0] {IDLE, SETUP, MERGE, PASS_END, DONE} state_t;
   state_t state_q, state_d;

   logic [LW-1:0]       len_q, w_q, b_q;
   logic                desc_q, err_q, src_q;
   logic [7:0]          pcnt_q;
   logic [LW-1:0]       ptr_q [2];
   logic [LW-1:0]       end_q [2];
   logic [2*ELEM_W-1:0] fifo_q [2][2];
   logic [1:0]          cnt_q [2];
   logic                wp_q [2];
   logic                rp_q [2];
   logic                off_q [2];
   logic                rvld_q, rtag_q, last_q, half_q;
   logic [ELEM_W-1:0]   even_q;
   logic [ADDR_W-1:0]   wptr_q;

   logic [ELEM_W-1:0]   head [2];
   logic                hv [2], ex [2], can [2], push [2], take [2];
   logic                active, rd_side, sel_a, fire, pair_done, bad_len, small_len;
   logic [ELEM_W-1:0]   sel_elem;
   logic [LW-1:0]       sum_a, sum_b, end_a, end_b, w_dbl;

   // Side 0 is run A, side 1 is run B. A response landing this cycle (push)
   // still counts as occupancy, so a side is exhausted only when nothing is pending.
   always_comb begin
      active = mem_ready_in && (state_q == MERGE);
      for (int s = 0; s < 2; s++) begin
         head[s] = off_q[s] ? fifo_q[s][rp_q[s]][2*ELEM_W-1:ELEM_W]
                            : fifo_q[s][rp_q[s]][ELEM_W-1:0];
         hv[s]   = (cnt_q[s] != 2'd0);
         push[s] = rvld_q && (rtag_q == s[0]);
         ex[s]   = (ptr_q[s] == end_q[s]) && !hv[s] && !push[s];
         can[s]  = (ptr_q[s] < end_q[s]) &&
                   ((cnt_q[s] == 2'd0) || (cnt_q[s] == 2'd1 && !push[s]));
      end
      rd_side     = (can[0] && can[1]) ? ~last_q : can[1];
      rd_en_out   = active && (can[0] || can[1]);
      rd_addr_out = ptr_q[rd_side][ADDR_W-1:0];
      sel_a       = hv[0] && (!hv[1] || (desc_q ? (head[0] >= head[1]) : (head[0] <= head[1])));
      fire        = active && ((hv[0] && (hv[1] || ex[1])) || (hv[1] && ex[0]));
      sel_elem    = sel_a ? head[0] : head[1];
      take[0]     = fire && sel_a;
      take[1]     = fire && !sel_a;
      wr_en_out   = fire && half_q;
      wr_addr_out = wptr_q;
      wr_data_out = {sel_elem, even_q};
      pair_done   = ex[0] && ex[1];
      sum_a       = b_q + w_q;
      sum_b       = b_q + (w_q << 1);
      end_a       = (sum_a < len_q) ? sum_a : len_q;
      end_b       = (sum_b < len_q) ? sum_b : len_q;
      w_dbl       = ((w_q << 1) > WMAX) ? WMAX : (w_q << 1);
      bad_len     = (stream_len_in == '0) || stream_len_in[0];
      small_len   = ({1'b0, stream_len_in} <= RUN0);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (start_in) state_d = (bad_len || small_len) ? DONE : SETUP;
         SETUP:    if (mem_ready_in) state_d = MERGE;
         MERGE:    if (mem_ready_in && pair_done) state_d = (sum_b >= len_q) ? PASS_END : SETUP;
         PASS_END: if (mem_ready_in) state_d = (w_dbl >= len_q) ? DONE : SETUP;
         DONE:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         len_q   <= '0;
         w_q     <= RUN0;
         b_q     <= '0;
         desc_q  <= 1'b0;
         err_q   <= 1'b0;
         src_q   <= 1'b0;
         pcnt_q  <= '0;
         rvld_q  <= 1'b0;
         rtag_q  <= 1'b0;
         last_q  <= 1'b0;
         half_q  <= 1'b0;
         wptr_q  <= '0;
         for (int s = 0; s < 2; s++) begin
            ptr_q[s] <= '0;
            end_q[s] <= '0;
            cnt_q[s] <= '0;
            wp_q[s]  <= 1'b0;
            rp_q[s]  <= 1'b0;
            off_q[s] <= 1'b0;
         end
      end else begin
         state_q <= state_d;
         rvld_q  <= rd_en_out;
         rtag_q  <= rd_side;
         if (rd_en_out) begin
            ptr_q[rd_side] <= ptr_q[rd_side] + LW'(1);
            last_q         <= rd_side;
         end
         for (int s = 0; s < 2; s++) begin
            if (push[s]) wp_q[s] <= ~wp_q[s];
            if (take[s]) begin
               off_q[s] <= ~off_q[s];
               if (off_q[s]) rp_q[s] <= ~rp_q[s];
            end
            cnt_q[s] <= cnt_q[s] + {1'b0, push[s]} - {1'b0, take[s] && off_q[s]};
         end
         if (fire) begin
            half_q <= ~half_q;
            if (half_q) wptr_q <= wptr_q + ADDR_W'(1);
         end
         case (state_q)
            IDLE: if (start_in) begin
               len_q  <= LW'(stream_len_in);
               desc_q <= descend_in;
               err_q  <= bad_len;
               src_q  <= 1'b0;
               pcnt_q <= '0;
               w_q    <= RUN0;
               b_q    <= '0;
            end
            SETUP: if (mem_ready_in) begin
               ptr_q[0] <= b_q >> 1;
               end_q[0] <= end_a >> 1;
               ptr_q[1] <= end_a >> 1;
               end_q[1] <= end_b >> 1;
               wptr_q   <= b_q[ADDR_W:1];
            end
            MERGE: if (mem_ready_in && pair_done) b_q <= sum_b;
            PASS_END: if (mem_ready_in) begin
               src_q  <= ~src_q;
               pcnt_q <= pcnt_q + 8'd1;
               w_q    <= w_dbl;
               b_q    <= '0;
            end
            default: ;
         endcase
      end
   end

   // Payload storage needs no reset; occupancy counters guard every read.
   always_ff @(posedge clock) begin
      for (int s = 0; s < 2; s++)
         if (push[s]) fifo_q[s][wp_q[s]] <= rd_data_in;
      if (fire && !half_q) even_q <= sel_elem;
   end

   assign src_bank_out = src_q;
   assign err_out      = err_q;
   assign pass_cnt_out = pcnt_q;
   assign busy_out     = (state_q == SETUP) || (state_q == MERGE) || (state_q == PASS_END);
   assign done_out     = (state_q == DONE);

endmodule
